// File: rtl/panel_loader_pkg.sv
// Shared types for the front-panel image loader: FSM states, timer phase
// select and the buffered image word.
package panel_loader_pkg;

  localparam int IMG_W = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LP_SETUP,
    S_LP_PRESS,
    S_LP_REL,
    S_SETTLE,
    S_DEP_SETUP,
    S_DEP_PRESS,
    S_DEP_REL,
    S_START_PC,
    S_SP_PRESS,
    S_SP_REL,
    S_RUN_WAIT_HI,
    S_RUN_WAIT_LO,
    S_DONE
  } state_t;

  // Selects which duration the phase timer is reloaded with.
  typedef enum logic {
    PH_HOLD,
    PH_SETTLE
  } phase_sel_t;

  typedef struct packed {
    logic [IMG_W-1:0] addr;
    logic [IMG_W-1:0] data;
    logic             last;
  } img_word_t;

endpackage

// File: rtl/panel_loader_fifo.sv
// Small synchronous FIFO for buffered image words. Pointers carry one extra
// wrap bit so full and empty are distinguished without a counter.
module panel_loader_fifo
  import panel_loader_pkg::*;
#(
  parameter type T     = img_word_t,
  parameter int  DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  T     wr_data,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/panel_image_loader.sv
// Front-panel image loader: buffers (addr, data) words and plays them into
// the panel switches/buttons with fixed hold and settle timing, then loads
// the start PC, raises run and reports completion when the CPU halts.
// Optional feature macro: PANEL_LOADER_AUTOINC_EN (skip load-PC for
// consecutive addresses, relying on the panel's post-deposit increment).
//
// state       | meaning
// ------------+------------------------------------------------
// IDLE        | waiting for the first image word
// LP_SETUP    | sw = address, settling before load-PC press
// LP_PRESS    | load_pc_btn held high
// LP_REL      | load_pc_btn released, sw still = address
// SETTLE      | gap between load-PC and deposit
// DEP_SETUP   | sw = data, settling before deposit press
// DEP_PRESS   | deposit_btn held high
// DEP_REL     | deposit released; holds here while FIFO is empty
// START_PC    | sw = run_pc, settling before final load-PC
// SP_PRESS    | load_pc_btn held high for start PC
// SP_REL      | load_pc_btn released
// RUN_WAIT_HI | run_sw high, waiting for CPU to report running
// RUN_WAIT_LO | waiting for CPU to halt
// DONE        | program finished, sticky until rst
module panel_image_loader
  import panel_loader_pkg::*;
#(
  parameter int WORD_W        = IMG_W,
  parameter int HOLD_CYCLES   = 10,
  parameter int SETTLE_CYCLES = 30,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_addr,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [WORD_W-1:0] run_pc,
  input  logic              run_led,
  output logic [WORD_W-1:0] sw,
  output logic              load_pc_btn,
  output logic              deposit_btn,
  output logic              run_sw,
  output logic              busy,
  output logic              done,
  output logic [15:0]       words_loaded
);

`ifdef PANEL_LOADER_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam int MAX_PHASE = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PHASE + 1);

  function automatic logic [CNT_W-1:0] phase_load(input phase_sel_t ph);
    return (ph == PH_SETTLE) ? CNT_W'(SETTLE_CYCLES - 1) : CNT_W'(HOLD_CYCLES - 1);
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  img_word_t          hold;
  img_word_t          head;
  img_word_t          wr_word;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               tc;
  logic [IMG_W-1:0]   next_addr;
  logic               skip_lp;

  assign wr_word   = '{addr: in_addr, data: in_data, last: in_last};
  assign in_ready  = ~fifo_full;
  assign tc        = (cnt == '0);
  assign next_addr = hold.addr + 1'b1;
  // Only reachable from DEP_REL, so a deposit has always happened already.
  assign skip_lp   = AUTOINC && (head.addr == next_addr);

  // Pop the head word when starting the image or after a finished deposit.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == S_IDLE) pop = 1'b1;
      else if (state == S_DEP_REL && tc && !hold.last) pop = 1'b1;
    end
  end

  panel_loader_fifo #(
    .T     (img_word_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid && in_ready),
    .pop     (pop),
    .wr_data (wr_word),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sequencer: phase timer, state and all registered panel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      hold         <= '0;
      sw           <= '0;
      load_pc_btn  <= 1'b0;
      deposit_btn  <= 1'b0;
      run_sw       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      words_loaded <= '0;
    end else begin
      done <= 1'b0;
      if (!tc) cnt <= cnt - 1'b1;
      case (state)
        S_IDLE: if (pop) begin
          hold  <= head;
          busy  <= 1'b1;
          sw    <= head.addr;
          cnt   <= phase_load(PH_HOLD);
          state <= S_LP_SETUP;
        end
        S_LP_SETUP: if (tc) begin
          load_pc_btn <= 1'b1;
          cnt         <= phase_load(PH_HOLD);
          state       <= S_LP_PRESS;
        end
        S_LP_PRESS: if (tc) begin
          load_pc_btn <= 1'b0;
          cnt         <= phase_load(PH_HOLD);
          state       <= S_LP_REL;
        end
        S_LP_REL: if (tc) begin
          cnt   <= phase_load(PH_SETTLE);
          state <= S_SETTLE;
        end
        S_SETTLE: if (tc) begin
          sw    <= hold.data;
          cnt   <= phase_load(PH_HOLD);
          state <= S_DEP_SETUP;
        end
        S_DEP_SETUP: if (tc) begin
          deposit_btn <= 1'b1;
          cnt         <= phase_load(PH_HOLD);
          state       <= S_DEP_PRESS;
        end
        S_DEP_PRESS: if (tc) begin
          deposit_btn <= 1'b0;
          if (words_loaded != 16'hFFFF) words_loaded <= words_loaded + 16'd1;
          cnt         <= phase_load(PH_HOLD);
          state       <= S_DEP_REL;
        end
        S_DEP_REL: if (tc) begin
          if (hold.last) begin
            sw    <= run_pc;
            cnt   <= phase_load(PH_HOLD);
            state <= S_START_PC;
          end else if (pop) begin
            hold <= head;
            cnt  <= phase_load(PH_HOLD);
            if (skip_lp) begin
              sw    <= head.data;
              state <= S_DEP_SETUP;
            end else begin
              sw    <= head.addr;
              state <= S_LP_SETUP;
            end
          end
        end
        S_START_PC: if (tc) begin
          load_pc_btn <= 1'b1;
          cnt         <= phase_load(PH_HOLD);
          state       <= S_SP_PRESS;
        end
        S_SP_PRESS: if (tc) begin
          load_pc_btn <= 1'b0;
          cnt         <= phase_load(PH_HOLD);
          state       <= S_SP_REL;
        end
        S_SP_REL: if (tc) begin
          run_sw <= 1'b1;
          state  <= S_RUN_WAIT_HI;
        end
        S_RUN_WAIT_HI: if (run_led) state <= S_RUN_WAIT_LO;
        S_RUN_WAIT_LO: if (!run_led) begin
          done   <= 1'b1;
          run_sw <= 1'b0;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_image_loader.sv
// Scoreboard bench for panel_image_loader: stimulus queues the expected
// button presses (kind + switch value); a monitor checks each press, its
// high time and switch stability, while the main flow checks timing/status.
module tb_panel_image_loader;

  localparam int W = 12;
  localparam int H = 10;
  localparam int S = 30;
`ifdef PANEL_LOADER_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_addr = '0;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic [W-1:0]  run_pc = '0;
  logic          run_led = 1'b0;
  logic [W-1:0]  sw;
  logic          load_pc_btn;
  logic          deposit_btn;
  logic          run_sw;
  logic          busy;
  logic          done;
  logic [15:0]   words_loaded;

  panel_image_loader #(
    .WORD_W(W), .HOLD_CYCLES(H), .SETTLE_CYCLES(S), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
    .run_pc(run_pc), .run_led(run_led), .sw(sw),
    .load_pc_btn(load_pc_btn), .deposit_btn(deposit_btn), .run_sw(run_sw),
    .busy(busy), .done(done), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           dep;
    logic [W-1:0] val;
  } exp_t;

  exp_t         exp_q[$];
  int           lp_times[$];
  int           dep_times[$];
  int           checks = 0;
  int           errors = 0;
  int           done_cnt = 0;
  int           full_seen = 0;
  int           last_acc = 0;
  bit           have_prev = 0;
  logic [W-1:0] prev_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic check_press(input bit dep, input logic [W-1:0] val);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_press: dep=%0d sw=%o, expected no press", dep, val);
    end else begin
      e = exp_q.pop_front();
      check("press_kind", 32'(dep), 32'(e.dep));
      check("press_sw", 32'(val), 32'(e.val));
    end
  endtask

  // Monitor: every button press is compared against the scoreboard.
  initial begin : monitor
    logic         prev_lp, prev_dep;
    int           lp_rise, dep_rise;
    logic [W-1:0] lp_sw, dep_sw;
    prev_lp = 0; prev_dep = 0; lp_rise = 0; dep_rise = 0; lp_sw = '0; dep_sw = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_lp = 0;
        prev_dep = 0;
      end else begin
        if (load_pc_btn && !prev_lp) begin
          check_press(1'b0, sw);
          lp_rise = cyc; lp_sw = sw; lp_times.push_back(cyc);
        end
        if (!load_pc_btn && prev_lp) begin
          check("lp_high_time", 32'(cyc - lp_rise), H);
          check("lp_sw_stable", 32'(sw), 32'(lp_sw));
        end
        if (deposit_btn && !prev_dep) begin
          check_press(1'b1, sw);
          dep_rise = cyc; dep_sw = sw; dep_times.push_back(cyc);
        end
        if (!deposit_btn && prev_dep) begin
          check("dep_high_time", 32'(cyc - dep_rise), H);
          check("dep_sw_stable", 32'(sw), 32'(dep_sw));
        end
        if (done) done_cnt++;
        prev_lp = load_pc_btn;
        prev_dep = deposit_btn;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Queue expected presses from a simple panel model, then hand the word over.
  task automatic push_word(input logic [W-1:0] a, input logic [W-1:0] d, input logic l);
    int guard = 0;
    logic [W-1:0] nxt = prev_addr + 12'd1;
    bit skip = AUTOINC && have_prev && (a == nxt);
    exp_t e;
    if (!skip) begin e.dep = 0; e.val = a; exp_q.push_back(e); end
    e.dep = 1; e.val = d; exp_q.push_back(e);
    if (l) begin e.dep = 0; e.val = run_pc; exp_q.push_back(e); end
    have_prev = 1;
    prev_addr = a;
    in_addr = a; in_data = d; in_last = l; in_valid = 1'b1;
    while (!in_ready && guard < 5000) begin
      full_seen++;
      guard++;
      @(negedge clk);
    end
    check("push_accept", 32'(in_ready), 1);
    @(negedge clk);
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete(); lp_times.delete(); dep_times.delete();
    done_cnt = 0; have_prev = 0; full_seen = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; run_led = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_run_sw(input int lim);
    int n = 0;
    while (!run_sw && n < lim) begin @(negedge clk); n++; end
    check("run_sw_reached", 32'(run_sw), 1);
  endtask

  task automatic wait_words(input int cnt, input int lim);
    int n = 0;
    while (words_loaded != 16'(cnt) && n < lim) begin @(negedge clk); n++; end
    check("words_reached", 32'(words_loaded), cnt);
  endtask

  task automatic wait_dep_hi(input int lim);
    int n = 0;
    while (!deposit_btn && n < lim) begin @(negedge clk); n++; end
    check("dep_press_reached", 32'(deposit_btn), 1);
  endtask

  task automatic pulse_run_led();
    run_led = 1'b1;
    repeat (50) @(negedge clk);
    run_led = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic single_word();
    int p2;
    run_pc = 12'o0200;
    push_word(12'o0200, 12'o7402, 1'b1);
    p2 = last_acc + 1;
    check("sw_before_pop", 32'(sw), 0);
    @(negedge clk);
    check("sw_lp_setup", 32'(sw), 32'(12'o0200));
    wait_run_sw(400);
    check("run_sw_time", 32'(cyc - p2), 6*H + S + 3*H);
    check("lp_count", lp_times.size(), 2);
    check("dep_count", dep_times.size(), 1);
    if (lp_times.size() == 2 && dep_times.size() == 1) begin
      check("lp_press_time", 32'(lp_times[0] - p2), H);
      check("lp_to_dep_time", 32'(dep_times[0] - lp_times[0]), 2*H + S + H);
      check("start_pc_press_time", 32'(lp_times[1] - p2), 6*H + S + H);
    end
    check("words_one", 32'(words_loaded), 1);
    check("busy_running", 32'(busy), 1);
    check("queue_empty_single", exp_q.size(), 0);
    pulse_run_led();
    check("done_once", done_cnt, 1);
    check("run_sw_cleared", 32'(run_sw), 0);
    check("busy_cleared", 32'(busy), 0);
    pulse_run_led();
    check("done_sticky", done_cnt, 1);
  endtask

  initial begin : main
    int p2;
    repeat (3) @(negedge clk);
    check("rst_sw", 32'(sw), 0);
    check("rst_lp", 32'(load_pc_btn), 0);
    check("rst_dep", 32'(deposit_btn), 0);
    check("rst_run_sw", 32'(run_sw), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_words", 32'(words_loaded), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    single_word();

    // 20 words back-to-back through an 8-deep buffer
    apply_reset();
    run_pc = 12'o1000;
    for (int i = 0; i < 20; i++)
      push_word(12'(12'o1000 + 2*i), 12'(12'o5000 + i), i == 19);
    wait_run_sw(4000);
    check("in_ready_low_when_full", 32'(full_seen > 0), 1);
    check("words_twenty", 32'(words_loaded), 20);
    check("lp_count_twenty", lp_times.size(), 21);
    check("dep_count_twenty", dep_times.size(), 20);
    check("queue_empty_twenty", exp_q.size(), 0);

    // consecutive addresses across the wrap
    apply_reset();
    run_pc = 12'o7776;
    push_word(12'o7776, 12'o0011, 1'b0);
    p2 = last_acc + 1;
    push_word(12'o7777, 12'o0022, 1'b0);
    push_word(12'o0000, 12'o0033, 1'b1);
    wait_run_sw(1000);
    check("lp_count_wrap", lp_times.size(), AUTOINC ? 2 : 4);
    check("dep_count_wrap", dep_times.size(), 3);
    if (lp_times.size() > 0)
      check("start_pc_time_wrap", 32'(lp_times[lp_times.size()-1] - p2),
            AUTOINC ? (6*H + S + 3*H + 3*H + H) : (3*(6*H + S) + H));
    check("words_wrap", 32'(words_loaded), 3);
    check("queue_empty_wrap", exp_q.size(), 0);

    // FIFO starvation between words
    apply_reset();
    run_pc = 12'o0300;
    push_word(12'o0300, 12'o1111, 1'b0);
    wait_words(1, 400);
    repeat (50) @(negedge clk);
    check("starve_lp_low", 32'(load_pc_btn), 0);
    check("starve_dep_low", 32'(deposit_btn), 0);
    check("starve_busy", 32'(busy), 1);
    check("starve_sw_held", 32'(sw), 32'(12'o1111));
    push_word(12'o0500, 12'o2222, 1'b1);
    p2 = last_acc + 1;
    wait_run_sw(500);
    check("lp_count_starve", lp_times.size(), 3);
    if (lp_times.size() == 3 && dep_times.size() == 2) begin
      check("resume_lp_time", 32'(lp_times[1] - p2), H);
      check("resume_dep_time", 32'(dep_times[1] - lp_times[1]), 2*H + S + H);
    end
    check("words_starve", 32'(words_loaded), 2);
    check("queue_empty_starve", exp_q.size(), 0);

    // reset during a deposit press, with a word still buffered
    apply_reset();
    run_pc = 12'o0400;
    push_word(12'o0400, 12'o1234, 1'b0);
    push_word(12'o0402, 12'o4321, 1'b0);
    push_word(12'o0404, 12'o5555, 1'b0);
    wait_words(1, 400);
    wait_dep_hi(200);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_dep", 32'(deposit_btn), 0);
    check("arst_lp", 32'(load_pc_btn), 0);
    check("arst_run_sw", 32'(run_sw), 0);
    check("arst_words", 32'(words_loaded), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    check("arst_busy", 32'(busy), 0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("flushed_busy", 32'(busy), 0);
    check("flushed_sw", 32'(sw), 0);
    single_word();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
